// File: rtl/int_sched_pkg.sv
// Shared definitions for the interrupt scheduler: register map, FSM encoding
// and the CLAIM word layout.
package int_sched_pkg;

  localparam int ADDR_IER   = 0;
  localparam int ADDR_IPR   = 1;
  localparam int ADDR_CLAIM = 2;
  localparam int ADDR_EOI   = 3;
  localparam int ADDR_MODE  = 4;

  localparam int CLAIM_VALID_BIT = 31;
  localparam int ID_W            = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Round-robin pointer successor, wrapping the last source back to 0.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id, input int n);
    return (int'(id) == n - 1) ? {ID_W{1'b0}} : id + 5'd1;
  endfunction

endpackage

// File: rtl/int_rr_arbiter.sv
// Combinational arbiter: fixed lowest-index priority or round-robin from a pointer.
module int_rr_arbiter
  import int_sched_pkg::*;
#(
  parameter int INT_NUM = 8
) (
  input  logic [INT_NUM-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               mode,
  output logic [INT_NUM-1:0] grant,
  output logic [ID_W-1:0]    id
);

  logic [INT_NUM-1:0] upper;
  logic [INT_NUM-1:0] pick;

  // Round-robin prefers requests at or above the pointer, else wraps to the lowest.
  always_comb begin
    upper = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      upper[i] = (i >= int'(ptr));
    end
    upper = upper & req;
    if (mode && (upper != '0)) begin
      pick = upper;
    end else begin
      pick = req;
    end
    grant = pick & (~pick + INT_NUM'(1));
    id = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      id = grant[i] ? (id | ID_W'(i)) : id;
    end
  end

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler with Wishbone register access, claim/EOI handshake and
// fixed or round-robin arbitration between level-sensitive sources.
module int_sched
  import int_sched_pkg::*;
#(
  parameter int INT_NUM = 8,
  parameter int Aw      = 3,
  parameter int SELw    = 4,
  parameter int TAGw    = 3,
  parameter int Dw      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [Dw-1:0]      sa_dat_i,
  input  logic [SELw-1:0]    sa_sel_i,
  input  logic [Aw-1:0]      sa_addr_i,
  input  logic [TAGw-1:0]    sa_tag_i,
  input  logic               sa_stb_i,
  input  logic               sa_cyc_i,
  input  logic               sa_we_i,
  output logic [Dw-1:0]      sa_dat_o,
  output logic               sa_ack_o,
  output logic               sa_err_o,
  output logic               sa_rty_o,
  input  logic [INT_NUM-1:0] int_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o
);

  state_t             state;
  logic [INT_NUM-1:0] ier, pend, req, grant, clear_mask;
  logic               mode;
  logic [ID_W-1:0]    ptr, svc_id, win_id;
  logic               access, rd, wr, claim_hit, claim_ok, eoi_ok, ier_wr;
  logic [Dw-1:0]      rdata;
  logic               unused_in;

  assign unused_in = ^{sa_cyc_i, sa_sel_i, sa_tag_i, sa_dat_i};
  assign sa_err_o  = 1'b0;
  assign sa_rty_o  = 1'b0;

  // One side effect per transfer: only the first cycle of a strobe counts.
  assign access    = sa_stb_i & ~sa_ack_o;
  assign rd        = access & ~sa_we_i;
  assign wr        = access & sa_we_i;
  assign req       = pend & ier;
  assign claim_hit = (state == ST_PEND) && (grant != '0);
  assign claim_ok  = rd && (sa_addr_i == Aw'(ADDR_CLAIM)) && claim_hit;
  assign ier_wr    = wr && (sa_addr_i == Aw'(ADDR_IER));
  assign eoi_ok    = wr && (sa_addr_i == Aw'(ADDR_EOI)) && (state == ST_SERVICE)
                     && (sa_dat_i[ID_W-1:0] == svc_id);

  int_rr_arbiter #(.INT_NUM(INT_NUM)) u_arb (
    .req  (req),
    .ptr  (ptr),
    .mode (mode),
    .grant(grant),
    .id   (win_id)
  );

  // Read-data mux for the register map.
  always_comb begin
    rdata = '0;
    case (sa_addr_i)
      Aw'(ADDR_IER):   rdata[INT_NUM-1:0] = ier;
      Aw'(ADDR_IPR):   rdata[INT_NUM-1:0] = pend;
      Aw'(ADDR_CLAIM): begin
        if (claim_hit) begin
          rdata[CLAIM_VALID_BIT] = 1'b1;
          rdata[ID_W-1:0]        = win_id;
        end else begin
          rdata = '0;
        end
      end
      Aw'(ADDR_MODE):  rdata[0] = mode;
      default:         rdata = '0;
    endcase
  end

  // Pending bits to drop this cycle: the claimed winner and newly disabled sources.
  always_comb begin
    clear_mask = '0;
    if (claim_ok) begin
      clear_mask = clear_mask | grant;
    end else begin
      clear_mask = clear_mask;
    end
    if (ier_wr) begin
      clear_mask = clear_mask | (ier & ~sa_dat_i[INT_NUM-1:0]);
    end else begin
      clear_mask = clear_mask;
    end
  end

  // Current id shown to the CPU side.
  always_comb begin
    case (state)
      ST_PEND:    irq_id_o = win_id;
      ST_SERVICE: irq_id_o = svc_id;
      default:    irq_id_o = 5'd0;
    endcase
  end

  // Bus handshake and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa_ack_o <= 1'b0;
      sa_dat_o <= '0;
    end else begin
      sa_ack_o <= sa_stb_i & ~sa_ack_o;
      if (rd) sa_dat_o <= rdata;
    end
  end

  // Configuration, pending latch and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ier  <= '0;
      pend <= '0;
      mode <= 1'b0;
      ptr  <= '0;
    end else begin
      pend <= (pend | (int_i & ier)) & ~clear_mask;
      if (ier_wr) ier <= sa_dat_i[INT_NUM-1:0];
      if (wr && (sa_addr_i == Aw'(ADDR_MODE))) mode <= sa_dat_i[0];
      if (claim_ok) ptr <= next_ptr(win_id, INT_NUM);
    end
  end

  // Scheduler FSM; irq_o is registered alongside the state it reflects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      svc_id <= '0;
      irq_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != '0) begin
            state <= ST_PEND;
            irq_o <= 1'b1;
          end else begin
            irq_o <= 1'b0;
          end
        end
        ST_PEND: begin
          if (claim_ok) begin
            state  <= ST_SERVICE;
            svc_id <= win_id;
            irq_o  <= 1'b0;
          end else if (req == '0) begin
            state <= ST_IDLE;
            irq_o <= 1'b0;
          end else begin
            irq_o <= 1'b1;
          end
        end
        ST_SERVICE: begin
          irq_o <= 1'b0;
          if (eoi_ok) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_sched.sv
// Scoreboard bench for int_sched: transaction-level reference model, read data
// checked by a monitor on ack, irq lines checked after each operation settles.
module tb_int_sched;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sa_dat_i = '0;
  logic [3:0]  sa_sel_i = '0;
  logic [2:0]  sa_addr_i = '0;
  logic [2:0]  sa_tag_i = '0;
  logic        sa_stb_i = 1'b0, sa_cyc_i = 1'b0, sa_we_i = 1'b0;
  logic [31:0] sa_dat_o;
  logic        sa_ack_o, sa_err_o, sa_rty_o;
  logic [N-1:0] int_i = '0;
  logic        irq_o;
  logic [4:0]  irq_id_o;

  int_sched dut (
    .clk(clk), .reset(reset),
    .sa_dat_i(sa_dat_i), .sa_sel_i(sa_sel_i), .sa_addr_i(sa_addr_i), .sa_tag_i(sa_tag_i),
    .sa_stb_i(sa_stb_i), .sa_cyc_i(sa_cyc_i), .sa_we_i(sa_we_i),
    .sa_dat_o(sa_dat_o), .sa_ack_o(sa_ack_o), .sa_err_o(sa_err_o), .sa_rty_o(sa_rty_o),
    .int_i(int_i), .irq_o(irq_o), .irq_id_o(irq_id_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_read; logic [31:0] val; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [N-1:0] m_ier, m_pend, m_int;
  logic         m_mode;
  int           m_ptr, m_svc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int model_winner();
    logic [N-1:0] r;
    int i;
    r = m_pend & m_ier;
    if (r == '0) return -1;
    for (int k = 0; k < N; k++) begin
      i = m_mode ? (m_ptr + k) % N : k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_state();
    int  w;
    bit  e_irq;
    logic [31:0] e_id;
    w = model_winner();
    e_irq = (m_svc < 0) && (w >= 0);
    e_id  = (m_svc >= 0) ? 32'(m_svc) : (e_irq ? 32'(w) : 32'd0);
    check("irq_o", {31'd0, irq_o}, {31'd0, e_irq});
    check("irq_id_o", {27'd0, irq_id_o}, e_id);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sa_stb_i = 1'b0; sa_cyc_i = 1'b0; sa_we_i = 1'b0;
    int_i = '0;
    m_ier = '0; m_pend = '0; m_int = '0; m_mode = 1'b0; m_ptr = 0; m_svc = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_int(input logic [N-1:0] v);
    @(posedge clk); #1;
    int_i = v;
    m_int = v;
    m_pend = m_pend | (v & m_ier);
    settle();
  endtask

  // One Wishbone transfer; the model is updated at issue, the expectation queued.
  task automatic bus(input logic [2:0] a, input logic we, input logic [31:0] d,
                     input logic [N-1:0] pulse, input bit use_c, input logic [31:0] c);
    exp_t e;
    logic [31:0] ex;
    int w;
    ex = 32'd0;
    if (!we) begin
      case (a)
        3'd0: ex = {24'd0, m_ier};
        3'd1: ex = {24'd0, m_pend};
        3'd2: begin
          w = model_winner();
          if (m_svc < 0 && w >= 0) begin
            ex = 32'h8000_0000 | 32'(w);
            m_svc = w;
            m_pend[w] = 1'b0;
            m_ptr = (w + 1) % N;
          end
        end
        3'd4: ex = {31'd0, m_mode};
        default: ex = 32'd0;
      endcase
    end else begin
      case (a)
        3'd0: begin m_ier = d[N-1:0]; m_pend = m_pend & m_ier; end
        3'd3: if (m_svc >= 0 && int'(d[4:0]) == m_svc) m_svc = -1;
        3'd4: m_mode = d[0];
        default: ;
      endcase
    end
    m_pend = m_pend | (pulse & m_ier) | (m_int & m_ier);
    if (use_c) ex = c;
    @(posedge clk); #1;
    sa_stb_i = 1'b1; sa_cyc_i = 1'b1; sa_we_i = we; sa_addr_i = a; sa_dat_i = d;
    sa_sel_i = 4'hF; sa_tag_i = 3'($urandom); int_i = m_int | pulse;
    e.is_read = !we; e.val = ex;
    exp_q.push_back(e);
    @(posedge clk); #1;
    sa_stb_i = 1'b0; sa_cyc_i = 1'b0; sa_we_i = 1'b0; int_i = m_int;
    settle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(a, 1'b1, d, '0, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a);
    bus(a, 1'b0, 32'd0, '0, 1'b0, 32'd0);
  endtask

  task automatic rdc(input logic [2:0] a, input logic [31:0] c);
    bus(a, 1'b0, 32'd0, '0, 1'b1, c);
  endtask

  // Monitor: every ack pops one expectation; reads compare the returned data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && sa_ack_o) begin
        check("err_rty", {30'd0, sa_err_o, sa_rty_o}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL ack_unexpected: got ack with empty scoreboard, required none");
        end else begin
          e = exp_q.pop_front();
          if (e.is_read) check("rd_data", sa_dat_o, e.val);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    int op, id;
    do_reset();
    #1;
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_id", {27'd0, irq_id_o}, 32'd0);
    check("rst_ack", {31'd0, sa_ack_o}, 32'd0);
    check("rst_dat", sa_dat_o, 32'd0);
    rdc(3'd0, 32'd0);
    rdc(3'd4, 32'd0);

    // Fixed priority: 0x28 -> id 3 first, then 5.
    wr(3'd0, 32'h0000_00FF);
    set_int(8'h28);
    set_int(8'h00);
    check("p1_irq", {31'd0, irq_o}, 32'd1);
    rdc(3'd2, 32'h8000_0003);
    check("p1_svc_irq", {31'd0, irq_o}, 32'd0);
    wr(3'd3, 32'd3);
    check("p1_id5", {27'd0, irq_id_o}, 32'd5);
    rdc(3'd2, 32'h8000_0005);
    wr(3'd3, 32'd5);

    // Round-robin with held 0x81 alternates 0,7,0,7.
    do_reset();
    wr(3'd0, 32'h0000_00FF);
    wr(3'd4, 32'd1);
    set_int(8'h81);
    rdc(3'd2, 32'h8000_0000); wr(3'd3, 32'd0);
    rdc(3'd2, 32'h8000_0007); wr(3'd3, 32'd7);
    rdc(3'd2, 32'h8000_0000); wr(3'd3, 32'd0);
    rdc(3'd2, 32'h8000_0007); wr(3'd3, 32'd7);
    set_int(8'h00);
    wr(3'd0, 32'd0);
    wr(3'd0, 32'h0000_00FF);
    wr(3'd4, 32'd0);

    // Mismatched EOI ignored.
    set_int(8'h04); set_int(8'h00);
    rdc(3'd2, 32'h8000_0002);
    wr(3'd3, 32'd4);
    check("eoi_bad_id", {27'd0, irq_id_o}, 32'd2);
    wr(3'd3, 32'd2);
    check("eoi_ok_irq", {31'd0, irq_o}, 32'd0);

    // Claim in IDLE, and a request pulse coinciding with a claim.
    rdc(3'd2, 32'd0);
    set_int(8'h01); set_int(8'h00);
    bus(3'd2, 1'b0, 32'd0, 8'h02, 1'b1, 32'h8000_0000);
    rdc(3'd1, 32'h0000_0002);
    wr(3'd3, 32'd0);
    rdc(3'd2, 32'h8000_0001);
    wr(3'd3, 32'd1);

    // IER clear drops pending; reset mid-service clears outputs at once.
    set_int(8'h04); set_int(8'h00);
    rdc(3'd1, 32'h0000_0004);
    wr(3'd0, 32'd0);
    rdc(3'd1, 32'd0);
    wr(3'd0, 32'h0000_00FF);
    set_int(8'h04); set_int(8'h00);
    rdc(3'd2, 32'h8000_0002);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq_o}, 32'd0);
    check("arst_id", {27'd0, irq_id_o}, 32'd0);
    check("arst_ack", {31'd0, sa_ack_o}, 32'd0);
    check("arst_dat", sa_dat_o, 32'd0);
    do_reset();
    rdc(3'd1, 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: set_int(N'($urandom & $urandom));
        2:    wr(3'd0, ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_00FF);
        3:    wr(3'd4, 32'($urandom_range(0, 1)));
        4, 5: rd(3'd2);
        6, 7: begin
          id = (m_svc >= 0 && $urandom_range(0, 3) != 0) ? m_svc : $urandom_range(0, 31);
          d = $urandom;
          d[4:0] = 5'(id);
          wr(3'd3, d);
        end
        8:    rd(3'($urandom_range(0, 7)));
        default: wr(3'($urandom_range(5, 7)), $urandom);
      endcase
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
